dma_bus_master: RTL and testbench

- Bus initiator that performs the OAM-style block copy on the memory-mapped byte bus: LENGTH bytes from {src_page, 8'h00} to DST_BASE.
- It sits on the master side of the address-decoded bus, alongside the CPU, and drives m_address/m_indata/m_load/m_store.
- It consumes m_outdata after the fixed read latency of the decoded regions.
- Bus outputs are all-zero whenever the block is not driving, so they can be OR-combined with the CPU's bus outputs.

---
 rtl/dma_bus_master_pkg.sv | 7 +
 rtl/dma_lat_counter.sv | 19 +
 rtl/dma_bus_master.sv | 72 +++++++
 tb/tb_dma_bus_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_master_pkg.sv
// dma_bus_master_pkg: shared bus widths and memory-map addresses for the byte bus masters.
package dma_bus_master_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] OAM_BASE = 16'hFE00;
  localparam logic [ADDR_W-1:0] DMA_REG = 16'hFF46;
endpackage

// File: rtl/dma_lat_counter.sv
// dma_lat_counter: read-latency down-counter; last marks the cycle read data is valid.
module dma_lat_counter #(
  parameter int READ_LATENCY = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic last
);
  localparam logic [2:0] INIT = 3'(READ_LATENCY - 1);
  logic [2:0] wcnt;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) wcnt <= '0;
    else if (load) wcnt <= INIT;
    else if (en && wcnt != 3'd0) wcnt <= wcnt - 3'd1;
  end
  assign last = wcnt == 3'd0;
endmodule

// File: rtl/dma_bus_master.sv
// dma_bus_master: bus initiator copying LENGTH bytes from {src_page,8'h00} to DST_BASE.
module dma_bus_master
  import dma_bus_master_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DST_BASE = OAM_BASE,
  parameter int LENGTH = 160,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        src_page,
  input  logic              bus_gnt,
  input  logic [DATA_W-1:0] m_outdata,
  output logic              bus_req,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_indata,
  output logic              m_load,
  output logic              m_store,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, REQ, READ, WAIT, WRITE, DONE} state_t;
  localparam logic [7:0] LAST = 8'(LENGTH - 1);
  state_t state, next;
  logic [7:0] page, idx;
  logic [DATA_W-1:0] data;
  logic wlast;
  dma_lat_counter #(.READ_LATENCY(READ_LATENCY)) u_lat (
    .clock(clock),
    .resetn(resetn),
    .load(state == READ),
    .en(state == WAIT),
    .last(wlast)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      page <= '0;
      idx <= '0;
      data <= '0;
    end else begin
      state <= next;
      if (start) begin
        page <= src_page;
        idx <= '0;
      end else if (state == WRITE && idx != LAST) idx <= idx + 8'd1;
      if (state == WAIT && wlast) data <= m_outdata;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = IDLE;
      REQ: next = bus_gnt ? READ : REQ;
      READ: next = WAIT;
      WAIT: next = wlast ? WRITE : WAIT;
      WRITE: next = idx == LAST ? DONE : (bus_gnt ? READ : REQ);
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
    // a restart overrides whatever the current transfer would do next
    if (start) next = REQ;
    bus_req = state inside {REQ, READ, WAIT, WRITE};
    busy = bus_req;
    done = state == DONE;
    m_load = state == READ;
    m_store = state == WRITE;
    m_address = m_load ? {page, idx} : m_store ? DST_BASE + {8'h00, idx} : '0;
    m_indata = m_store ? data : '0;
  end
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: three builds driven together, each checked every cycle against a byte-timeline model.
module tb_dma_bus_master;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic bus_gnt = 1'b0;
  logic [7:0] src_page = 8'h00;
  int cyc = 0;
  int tot = 0;
  int bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int RL = g == 1 ? 4 : 2;
    localparam int LEN = g == 2 ? 1 : 160;
    localparam logic [15:0] DST = g == 1 ? 16'hFFC0 : 16'hFE00;
    logic bus_req, busy, done, m_load, m_store;
    logic [15:0] m_address;
    logic [7:0] m_indata;
    logic [7:0] m_outdata = 8'h00;
    dma_bus_master #(.DST_BASE(DST), .LENGTH(LEN), .READ_LATENCY(RL)) dut (
      .clock(clock),
      .resetn(resetn),
      .start(start),
      .src_page(src_page),
      .bus_gnt(bus_gnt),
      .m_outdata(m_outdata),
      .bus_req(bus_req),
      .m_address(m_address),
      .m_indata(m_indata),
      .m_load(m_load),
      .m_store(m_store),
      .busy(busy),
      .done(done)
    );
    // model: a transfer is either waiting for grant or m_t cycles into a byte (load at 0, store at RL+1)
    bit m_act = 1'b0;
    bit m_wt = 1'b0;
    bit m_done = 1'b0;
    int m_t = 0;
    logic [7:0] m_idx = 8'h00;
    logic [7:0] m_page = 8'h00;
    always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        m_act <= 1'b0;
        m_wt <= 1'b0;
        m_done <= 1'b0;
        m_t <= 0;
        m_idx <= 8'h00;
        m_page <= 8'h00;
      end else begin
        m_done <= 1'b0;
        if (start) begin
          m_act <= 1'b1;
          m_wt <= 1'b1;
          m_page <= src_page;
          m_idx <= 8'h00;
          m_t <= 0;
        end else if (m_act) begin
          if (m_wt) begin
            m_wt <= !bus_gnt;
            m_t <= 0;
          end else if (m_t == RL + 1) begin
            if (int'(m_idx) == LEN - 1) begin
              m_act <= 1'b0;
              m_done <= 1'b1;
            end else begin
              m_idx <= m_idx + 8'd1;
              m_wt <= !bus_gnt;
              m_t <= 0;
            end
          end else m_t <= m_t + 1;
        end
      end
    end
    logic e_ld, e_st;
    logic [28:0] exp_v, act_v;
    always_comb begin
      e_ld = m_act && !m_wt && m_t == 0;
      e_st = m_act && !m_wt && m_t == RL + 1;
      exp_v = {m_act, m_act, m_done, e_ld, e_st,
               e_ld ? {m_page, m_idx} : e_st ? DST + {8'h00, m_idx} : 16'h0000,
               e_st ? m_idx ^ 8'h5A : 8'h00};
    end
    assign act_v = {bus_req, busy, done, m_load, m_store, m_address, m_indata};
    // source memory answers exactly RL cycles after a load; any other cycle returns junk
    logic hv[4] = '{default: 1'b0};
    logic [15:0] ha[4] = '{default: 16'h0000};
    int n_load = 0, n_store = 0, n_done = 0;
    int first_load_cyc = 0, first_store_cyc = 0, done_cyc = 0;
    logic [15:0] last_load = 16'h0000, last_store = 16'h0000;
    logic [7:0] last_sdata = 8'h00;
    always @(negedge clock) begin
      for (int k = 3; k > 0; k--) begin
        hv[k] <= hv[k-1];
        ha[k] <= ha[k-1];
      end
      hv[0] <= m_load;
      ha[0] <= m_address;
      m_outdata <= hv[RL-1] ? ha[RL-1][7:0] ^ 8'h5A : 8'($urandom);
      if (m_load) begin
        if (n_load == 0) first_load_cyc <= cyc;
        n_load <= n_load + 1;
        last_load <= m_address;
      end
      if (m_store) begin
        if (n_store == 0) first_store_cyc <= cyc;
        n_store <= n_store + 1;
        last_store <= m_address;
        last_sdata <= m_indata;
      end
      if (done) begin
        n_done <= n_done + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, e);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    chk("cycle_u0", 32'(u[0].act_v), 32'(u[0].exp_v));
    chk("cycle_u1", 32'(u[1].act_v), 32'(u[1].exp_v));
    chk("cycle_u2", 32'(u[2].act_v), 32'(u[2].exp_v));
    @(posedge clock);
    #2;
  endtask

  int s, g, l, st, d;

  initial begin
    repeat (3) tick();
    chk("reset_u0", 32'(u[0].act_v), 32'h0);
    chk("reset_u1", 32'(u[1].act_v), 32'h0);
    chk("reset_u2", 32'(u[2].act_v), 32'h0);
    resetn = 1'b1;
    repeat (2) tick();

    bus_gnt = 1'b1;
    src_page = 8'hC0;
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    for (int k = 0; k < 1200 && u[1].n_done == 0; k++) tick();
    chk("basic_loads", u[0].n_load, 160);
    chk("basic_stores", u[0].n_store, 160);
    chk("basic_done_cnt", u[0].n_done, 1);
    chk("basic_done_cyc", u[0].done_cyc - s, 641);
    chk("basic_first_load_cyc", u[0].first_load_cyc - s, 1);
    chk("basic_last_load", u[0].last_load, 16'hC09F);
    chk("basic_last_store", u[0].last_store, 16'hFE9F);
    chk("basic_last_data", u[0].last_sdata, 8'hC5);
    chk("lat4_store_gap", u[1].first_store_cyc - u[1].first_load_cyc, 5);
    chk("lat4_done_cnt", u[1].n_done, 1);
    chk("lat4_done_cyc", u[1].done_cyc - s, 961);
    chk("lat4_wrap_store", u[1].last_store, 16'h005F);
    chk("len1_done_cyc", u[2].done_cyc - s, 5);

    bus_gnt = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = u[0].n_load;
    st = u[0].n_store;
    d = u[0].n_done;
    repeat (10) tick();
    chk("arb_req_held", u[0].bus_req, 1);
    chk("arb_no_load", u[0].n_load - l, 0);
    bus_gnt = 1'b1;
    for (int k = 0; k < 100 && u[0].n_load - l < 6; k++) tick();
    chk("arb_load5", u[0].last_load, 16'hC005);
    bus_gnt = 1'b0;
    repeat (8) tick();
    chk("arb_store5", u[0].last_store, 16'hFE05);
    chk("arb_store_cnt", u[0].n_store - st, 6);
    chk("arb_hold_req", u[0].bus_req, 1);
    chk("arb_hold_noload", u[0].n_load - l, 6);
    bus_gnt = 1'b1;
    for (int k = 0; k < 20 && u[0].n_load - l == 6; k++) tick();
    chk("arb_resume", u[0].last_load, 16'hC006);
    for (int k = 0; k < 800 && u[0].n_done == d; k++) tick();
    chk("arb_done", u[0].n_done - d, 1);

    src_page = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    st = u[0].n_store;
    d = u[0].n_done;
    for (int k = 0; k < 200 && u[0].n_store - st < 20; k++) tick();
    src_page = 8'h90;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = u[0].n_load;
    for (int k = 0; k < 20 && u[0].n_load == l; k++) tick();
    chk("restart_load", u[0].last_load, 16'h9000);
    for (int k = 0; k < 800 && u[0].n_done == d; k++) tick();
    chk("restart_stores", u[0].n_store - st, 180);
    chk("restart_done", u[0].n_done - d, 1);

    src_page = 8'hC0;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = u[0].n_load;
    d = u[0].n_done;
    for (int k = 0; k < 300 && u[0].n_load - l < 51; k++) tick();
    chk("rst_at_load50", u[0].last_load, 16'hC032);
    resetn = 1'b0;
    #1;
    chk("async_rst_out", 32'(u[0].act_v), 32'h0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("rst_no_done", u[0].n_done - d, 0);
    l = u[0].n_load;
    st = u[0].n_store;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && u[0].n_store == st; k++) tick();
    chk("fresh_one_load", u[0].n_load - l, 1);
    chk("fresh_load", u[0].last_load, 16'hC000);
    chk("fresh_store", u[0].last_store, 16'hFE00);
    chk("fresh_data", u[0].last_sdata, 8'h5A);
    for (int k = 0; k < 800 && u[0].n_done == d; k++) tick();
    chk("fresh_done", u[0].n_done - d, 1);

    bus_gnt = 1'b0;
    src_page = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    d = u[2].n_done;
    repeat (2) tick();
    bus_gnt = 1'b1;
    tick();
    g = cyc;
    for (int k = 0; k < 20 && u[2].n_done == d; k++) tick();
    chk("len1_done_gnt", u[2].done_cyc - g, 4);
    chk("len1_load", u[2].last_load, 16'hFF00);
    chk("len1_store", u[2].last_store, 16'hFE00);
    chk("len1_data", u[2].last_sdata, 8'h5A);

    repeat (4000) begin
      bus_gnt = $urandom_range(0, 9) < 7;
      start = $urandom_range(0, 249) == 0;
      src_page = 8'($urandom);
      resetn = $urandom_range(0, 1499) != 0;
      tick();
    end
    resetn = 1'b1;
    start = 1'b0;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
